// File: rtl/id_issue.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : id_issue                                                   |
// | Description : RV32I subset decode/issue stage feeding the execute ALU.   |
// |               Optional macro ID_ILLEGAL_HALT_EN: halt on illegal inst.   |
// | Revision    : 1.0                                                        |
// +--------------------------------------------------------------------------+
module id_issue #(
  parameter int SETTLE_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_valid,
  output logic        inst_ready,
  input  logic [31:0] inst,
  input  logic [31:0] inst_pc,
  output logic [4:0]  rs1_addr,
  output logic [4:0]  rs2_addr,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  output logic [31:0] pc,
  output logic [31:0] reg_1,
  output logic [31:0] reg_2,
  output logic [31:0] imm,
  output logic [2:0]  aluop,
  output logic        pc_en,
  output logic        imm_en,
  output logic        ex_en,
  output logic        wb_valid,
  output logic [4:0]  rd_addr,
  output logic        rd_we,
  output logic        illegal
);

  localparam logic [2:0] c_IDLE   = 3'd0;
  localparam logic [2:0] c_DECODE = 3'd1;
  localparam logic [2:0] c_SETTLE = 3'd2;
  localparam logic [2:0] c_STROBE = 3'd3;
  localparam logic [2:0] c_WB     = 3'd4;
`ifdef ID_ILLEGAL_HALT_EN
  localparam logic [2:0] c_HALT   = 3'd5;
`endif

  localparam logic [2:0] c_OP_OR  = 3'd0;
  localparam logic [2:0] c_OP_AND = 3'd1;
  localparam logic [2:0] c_OP_XOR = 3'd2;
  localparam logic [2:0] c_OP_ADD = 3'd3;
  localparam logic [2:0] c_OP_SUB = 3'd4;

  localparam logic [6:0] c_OPC_REG   = 7'b0110011;
  localparam logic [6:0] c_OPC_IMM   = 7'b0010011;
  localparam logic [6:0] c_OPC_LUI   = 7'b0110111;
  localparam logic [6:0] c_OPC_AUIPC = 7'b0010111;

  localparam logic [3:0] c_SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

  logic [2:0]  r_state;
  logic [2:0]  w_state_nxt;
  logic [3:0]  r_cnt;
  logic [31:0] r_inst;
  logic [31:0] r_inst_pc;
  logic        r_ready;
  logic        r_illegal;

  logic [2:0]  w_f3_op;
  logic        w_f3_ok;
  logic        w_legal;
  logic        w_use_rs1;
  logic        w_use_rs2;
  logic        w_pc_en;
  logic        w_imm_en;
  logic [2:0]  w_aluop;
  logic [31:0] w_imm;

  // funct3 mapping shared by register and immediate forms
  always_comb begin
    w_f3_ok = 1'b1;
    w_f3_op = c_OP_ADD;
    case (r_inst[14:12])
      3'b110:  w_f3_op = c_OP_OR;
      3'b111:  w_f3_op = c_OP_AND;
      3'b100:  w_f3_op = c_OP_XOR;
      3'b000:  w_f3_op = c_OP_ADD;
      default: w_f3_ok = 1'b0;
    endcase
  end

  always_comb begin
    w_legal   = 1'b0;
    w_use_rs1 = 1'b0;
    w_use_rs2 = 1'b0;
    w_pc_en   = 1'b0;
    w_imm_en  = 1'b0;
    w_aluop   = c_OP_ADD;
    w_imm     = 32'd0;
    case (r_inst[6:0])
      c_OPC_REG: begin
        if (r_inst[31:25] == 7'b0000000 && w_f3_ok) begin
          w_legal   = 1'b1;
          w_aluop   = w_f3_op;
          w_use_rs1 = 1'b1;
          w_use_rs2 = 1'b1;
        end else if (r_inst[31:25] == 7'b0100000 && r_inst[14:12] == 3'b000) begin
          w_legal   = 1'b1;
          w_aluop   = c_OP_SUB;
          w_use_rs1 = 1'b1;
          w_use_rs2 = 1'b1;
        end
      end
      c_OPC_IMM: begin
        if (w_f3_ok) begin
          w_legal   = 1'b1;
          w_aluop   = w_f3_op;
          w_use_rs1 = 1'b1;
          w_imm_en  = 1'b1;
          w_imm     = {{20{r_inst[31]}}, r_inst[31:20]};
        end
      end
      c_OPC_LUI: begin
        w_legal  = 1'b1;
        w_imm_en = 1'b1;
        w_imm    = {r_inst[31:12], 12'h000};
      end
      c_OPC_AUIPC: begin
        w_legal  = 1'b1;
        w_pc_en  = 1'b1;
        w_imm_en = 1'b1;
        w_imm    = {r_inst[31:12], 12'h000};
      end
      default: ;
    endcase
  end

  assign rs1_addr = w_use_rs1 ? r_inst[19:15] : 5'd0;
  assign rs2_addr = w_use_rs2 ? r_inst[24:20] : 5'd0;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_IDLE:   if (inst_valid) w_state_nxt = c_DECODE;
      c_DECODE: begin
        if (w_legal) begin
          w_state_nxt = c_SETTLE;
        end else begin
`ifdef ID_ILLEGAL_HALT_EN
          w_state_nxt = c_HALT;
`else
          w_state_nxt = c_IDLE;
`endif
        end
      end
      c_SETTLE: if (r_cnt == 4'd0) w_state_nxt = c_STROBE;
      c_STROBE: w_state_nxt = c_WB;
      c_WB:     w_state_nxt = c_IDLE;
`ifdef ID_ILLEGAL_HALT_EN
      c_HALT:   w_state_nxt = c_HALT;
`endif
      default:  w_state_nxt = c_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= c_IDLE;
      r_cnt     <= 4'd0;
      r_inst    <= 32'd0;
      r_inst_pc <= 32'd0;
      r_ready   <= 1'b0;
      r_illegal <= 1'b0;
      pc        <= 32'd0;
      reg_1     <= 32'd0;
      reg_2     <= 32'd0;
      imm       <= 32'd0;
      aluop     <= 3'd0;
      pc_en     <= 1'b0;
      imm_en    <= 1'b0;
      rd_addr   <= 5'd0;
      rd_we     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      // ready is registered so it stays low until the first edge after reset release
      r_ready   <= (w_state_nxt == c_IDLE);
      r_illegal <= (r_state == c_DECODE) && !w_legal;
      if (r_state == c_IDLE && inst_valid) begin
        r_inst    <= inst;
        r_inst_pc <= inst_pc;
      end
      if (r_state == c_DECODE) begin
        if (w_legal) begin
          pc      <= r_inst_pc;
          reg_1   <= w_use_rs1 ? rs1_data : 32'd0;
          reg_2   <= w_use_rs2 ? rs2_data : 32'd0;
          imm     <= w_imm;
          aluop   <= w_aluop;
          pc_en   <= w_pc_en;
          imm_en  <= w_imm_en;
          rd_addr <= r_inst[11:7];
          rd_we   <= |r_inst[11:7];
          r_cnt   <= c_SETTLE_LOAD;
        end else begin
          rd_we   <= 1'b0;
        end
      end else if (r_state == c_SETTLE && r_cnt != 4'd0) begin
        r_cnt <= r_cnt - 4'd1;
      end
    end
  end

  assign inst_ready = r_ready;
  assign illegal    = r_illegal;
  assign ex_en      = (r_state == c_STROBE);
  assign wb_valid   = (r_state == c_WB);

endmodule
`default_nettype wire

// File: tb/tb_id_issue.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_id_issue                                                |
// | Description : Self-checking bench for id_issue (SETTLE_CYCLES 1 and 4).  |
// | Revision    : 1.0                                                        |
// +--------------------------------------------------------------------------+
module tb_id_issue;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] inst = 32'd0;
  logic [31:0] inst_pc = 32'd0;
  logic valid_a = 1'b0, valid_b = 1'b0;
  logic sel = 1'b0;
  logic [31:0] regs [32];

  int n_pass = 0;
  int n_total = 0;

  logic        ready_a, ready_b, pce_a, pce_b, ime_a, ime_b, ex_a, ex_b;
  logic        wb_a, wb_b, rdwe_a, rdwe_b, ill_a, ill_b;
  logic [4:0]  rs1_a, rs1_b, rs2_a, rs2_b, rd_a, rd_b;
  logic [31:0] rs1d_a, rs1d_b, rs2d_a, rs2d_b, pc_a, pc_b;
  logic [31:0] r1_a, r1_b, r2_a, r2_b, imm_a, imm_b;
  logic [2:0]  op_a, op_b;

  // register file: combinational read, x0 reads zero
  assign rs1d_a = (rs1_a == 5'd0) ? 32'd0 : regs[rs1_a];
  assign rs2d_a = (rs2_a == 5'd0) ? 32'd0 : regs[rs2_a];
  assign rs1d_b = (rs1_b == 5'd0) ? 32'd0 : regs[rs1_b];
  assign rs2d_b = (rs2_b == 5'd0) ? 32'd0 : regs[rs2_b];

  id_issue #(.SETTLE_CYCLES(1)) dut_a (
    .clk(clk), .rst(rst), .inst_valid(valid_a), .inst_ready(ready_a),
    .inst(inst), .inst_pc(inst_pc), .rs1_addr(rs1_a), .rs2_addr(rs2_a),
    .rs1_data(rs1d_a), .rs2_data(rs2d_a), .pc(pc_a), .reg_1(r1_a), .reg_2(r2_a),
    .imm(imm_a), .aluop(op_a), .pc_en(pce_a), .imm_en(ime_a), .ex_en(ex_a),
    .wb_valid(wb_a), .rd_addr(rd_a), .rd_we(rdwe_a), .illegal(ill_a));

  id_issue #(.SETTLE_CYCLES(4)) dut_b (
    .clk(clk), .rst(rst), .inst_valid(valid_b), .inst_ready(ready_b),
    .inst(inst), .inst_pc(inst_pc), .rs1_addr(rs1_b), .rs2_addr(rs2_b),
    .rs1_data(rs1d_b), .rs2_data(rs2d_b), .pc(pc_b), .reg_1(r1_b), .reg_2(r2_b),
    .imm(imm_b), .aluop(op_b), .pc_en(pce_b), .imm_en(ime_b), .ex_en(ex_b),
    .wb_valid(wb_b), .rd_addr(rd_b), .rd_we(rdwe_b), .illegal(ill_b));

  wire        ob_ready = sel ? ready_b : ready_a;
  wire [4:0]  ob_rs1   = sel ? rs1_b : rs1_a;
  wire [4:0]  ob_rs2   = sel ? rs2_b : rs2_a;
  wire [31:0] ob_pc    = sel ? pc_b : pc_a;
  wire [31:0] ob_r1    = sel ? r1_b : r1_a;
  wire [31:0] ob_r2    = sel ? r2_b : r2_a;
  wire [31:0] ob_imm   = sel ? imm_b : imm_a;
  wire [2:0]  ob_op    = sel ? op_b : op_a;
  wire        ob_pce   = sel ? pce_b : pce_a;
  wire        ob_ime   = sel ? ime_b : ime_a;
  wire        ob_ex    = sel ? ex_b : ex_a;
  wire        ob_wb    = sel ? wb_b : wb_a;
  wire [4:0]  ob_rd    = sel ? rd_b : rd_a;
  wire        ob_rdwe  = sel ? rdwe_b : rdwe_a;
  wire        ob_ill   = sel ? ill_b : ill_a;

  // Legal encodings; -1 means "any value". kind: 0=reg-reg, 1=reg-imm, 2=LUI, 3=AUIPC
  typedef struct { int opc; int f3; int f7; int op; int kind; } enc_t;
  enc_t tbl [11];

  typedef struct packed {
    logic legal; logic [2:0] op; logic pc_en; logic imm_en;
    logic [31:0] imm; logic [4:0] rs1; logic [4:0] rs2; logic [4:0] rd;
  } exp_t;

  function automatic exp_t model(input logic [31:0] w);
    exp_t e;
    e = '0;
    e.rd = w[11:7];
    for (int i = 0; i < 11; i++) begin
      if (int'(w[6:0]) == tbl[i].opc &&
          (tbl[i].f3 < 0 || int'(w[14:12]) == tbl[i].f3) &&
          (tbl[i].f7 < 0 || int'(w[31:25]) == tbl[i].f7)) begin
        e.legal = 1'b1;
        e.op    = 3'(tbl[i].op);
        case (tbl[i].kind)
          0: begin e.rs1 = w[19:15]; e.rs2 = w[24:20]; end
          1: begin e.rs1 = w[19:15]; e.imm_en = 1'b1; e.imm = 32'($signed(w[31:20])); end
          2: begin e.imm_en = 1'b1; e.imm = w & 32'hFFFF_F000; end
          default: begin e.pc_en = 1'b1; e.imm_en = 1'b1; e.imm = w & 32'hFFFF_F000; end
        endcase
      end
    end
    return e;
  endfunction

  function automatic logic [31:0] rand_legal();
    logic [31:0] w;
    int i;
    i = int'($urandom_range(0, 10));
    w = $urandom;
    w[6:0] = 7'(tbl[i].opc);
    if (tbl[i].f3 >= 0) w[14:12] = 3'(tbl[i].f3);
    if (tbl[i].f7 >= 0) w[31:25] = 7'(tbl[i].f7);
    return w;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  // Drives one instruction into the selected DUT and checks every cycle until idle.
  task automatic run_inst(input logic [31:0] w, input logic [31:0] ipc, input int settle);
    exp_t e;
    logic [31:0] x1, x2;
    logic exp_rdy;
    int n;
    e  = model(w);
    x1 = (e.rs1 == 5'd0) ? 32'd0 : regs[e.rs1];
    x2 = (e.rs2 == 5'd0) ? 32'd0 : regs[e.rs2];
    n = 0;
    while (ob_ready !== 1'b1 && n < 40) begin @(negedge clk); n++; end
    n_total++;
    if (ob_ready !== 1'b1) begin
      $display("FAIL ready_wait: inst_ready=%b required 1 within 40 cycles", ob_ready);
      return;
    end
    n_pass++;
    inst = w; inst_pc = ipc;
    if (sel) valid_b = 1'b1; else valid_a = 1'b1;
    @(posedge clk);
    @(negedge clk);
    valid_a = 1'b0; valid_b = 1'b0;
    inst = $urandom; inst_pc = $urandom;
    n_total++;
    if (ob_rs1 !== e.rs1 || ob_rs2 !== e.rs2 || ob_ready !== 1'b0 || ob_ex !== 1'b0) begin
      $display("FAIL decode inst=%h: rs1=%0d rs2=%0d rdy=%b ex=%b required rs1=%0d rs2=%0d rdy=0 ex=0",
               w, ob_rs1, ob_rs2, ob_ready, ob_ex, e.rs1, e.rs2);
    end else n_pass++;
    if (!e.legal) begin
`ifdef ID_ILLEGAL_HALT_EN
      exp_rdy = 1'b0;
`else
      exp_rdy = 1'b1;
`endif
      @(negedge clk);
      n_total++;
      if (ob_ill !== 1'b1 || ob_ex !== 1'b0 || ob_wb !== 1'b0 || ob_ready !== exp_rdy) begin
        $display("FAIL illegal_pulse inst=%h: ill=%b ex=%b wb=%b rdy=%b required 1 0 0 %b",
                 w, ob_ill, ob_ex, ob_wb, ob_ready, exp_rdy);
      end else n_pass++;
      @(negedge clk);
      n_total++;
      if (ob_ill !== 1'b0 || ob_ex !== 1'b0 || ob_ready !== exp_rdy) begin
        $display("FAIL illegal_end inst=%h: ill=%b ex=%b rdy=%b required 0 0 %b",
                 w, ob_ill, ob_ex, ob_ready, exp_rdy);
      end else n_pass++;
      return;
    end
    for (int k = 0; k <= settle; k++) begin
      @(negedge clk);
      n_total++;
      if (ob_ex !== (k == settle) || ob_wb !== 1'b0 || ob_ready !== 1'b0 ||
          ob_pc !== ipc || ob_r1 !== x1 || ob_r2 !== x2 || ob_imm !== e.imm ||
          ob_op !== e.op || ob_pce !== e.pc_en || ob_ime !== e.imm_en) begin
        $display("FAIL bundle inst=%h cyc=%0d: ex=%b wb=%b rdy=%b pc=%h r1=%h r2=%h imm=%h op=%0d pce=%b ime=%b required ex=%b wb=0 rdy=0 pc=%h r1=%h r2=%h imm=%h op=%0d pce=%b ime=%b",
                 w, k, ob_ex, ob_wb, ob_ready, ob_pc, ob_r1, ob_r2, ob_imm, ob_op, ob_pce, ob_ime,
                 (k == settle), ipc, x1, x2, e.imm, e.op, e.pc_en, e.imm_en);
      end else n_pass++;
    end
    @(negedge clk);
    n_total++;
    if (ob_ex !== 1'b0 || ob_wb !== 1'b1 || ob_rd !== e.rd || ob_rdwe !== (e.rd != 5'd0)) begin
      $display("FAIL writeback inst=%h: ex=%b wb=%b rd=%0d we=%b required ex=0 wb=1 rd=%0d we=%b",
               w, ob_ex, ob_wb, ob_rd, ob_rdwe, e.rd, (e.rd != 5'd0));
    end else n_pass++;
    @(negedge clk);
    n_total++;
    if (ob_wb !== 1'b0 || ob_ready !== 1'b1 || ob_ex !== 1'b0) begin
      $display("FAIL idle_return inst=%h: wb=%b rdy=%b ex=%b required 0 1 0", w, ob_wb, ob_ready, ob_ex);
    end else n_pass++;
  endtask

  task automatic test_reset();
    #2;
    n_total++;
    if ({ready_a, ex_a, wb_a, ill_a, rdwe_a, pce_a, ime_a, pc_a, r1_a, r2_a, imm_a, op_a, rd_a, rs1_a, rs2_a} !== '0 ||
        {ready_b, ex_b, wb_b, ill_b, rdwe_b, pc_b, r1_b, imm_b} !== '0) begin
      $display("FAIL reset_outputs: rdy=%b ex=%b wb=%b pc=%h r1=%h imm=%h required all zero",
               ready_a, ex_a, wb_a, pc_a, r1_a, imm_a);
    end else n_pass++;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_total++;
    if (ready_a !== 1'b1 || ready_b !== 1'b1) begin
      $display("FAIL ready_after_reset: a=%b b=%b required 1 1", ready_a, ready_b);
    end else n_pass++;
  endtask

  task automatic test_directed();
    sel = 1'b0;
    regs[1] = 32'd5; regs[2] = 32'd7;
    run_inst(32'h002081B3, 32'h0000_0040, 1);
    n_total++;
    if (ob_r1 !== 32'd5 || ob_r2 !== 32'd7 || ob_op !== 3'd3 || ob_ime !== 1'b0 ||
        ob_pce !== 1'b0 || ob_rd !== 5'd3 || ob_rdwe !== 1'b1) begin
      $display("FAIL add_const: r1=%0d r2=%0d op=%0d ime=%b pce=%b rd=%0d we=%b required 5 7 3 0 0 3 1",
               ob_r1, ob_r2, ob_op, ob_ime, ob_pce, ob_rd, ob_rdwe);
    end else n_pass++;
    run_inst(32'h407302B3, 32'h0000_0044, 1);
    n_total++;
    if (ob_rs1 !== 5'd6 || ob_rs2 !== 5'd7 || ob_op !== 3'd4 || ob_rd !== 5'd5 || ob_rdwe !== 1'b1) begin
      $display("FAIL sub_const: rs1=%0d rs2=%0d op=%0d rd=%0d we=%b required 6 7 4 5 1",
               ob_rs1, ob_rs2, ob_op, ob_rd, ob_rdwe);
    end else n_pass++;
    run_inst(32'hFFF00093, 32'h0000_0048, 1);
    n_total++;
    if (ob_imm !== 32'hFFFF_FFFF || ob_ime !== 1'b1 || ob_op !== 3'd3 || ob_r1 !== 32'd0) begin
      $display("FAIL addi_const: imm=%h ime=%b op=%0d r1=%h required ffffffff 1 3 0",
               ob_imm, ob_ime, ob_op, ob_r1);
    end else n_pass++;
    run_inst(32'h12345217, 32'h0000_0100, 1);
    n_total++;
    if (ob_pc !== 32'h100 || ob_pce !== 1'b1 || ob_imm !== 32'h1234_5000 || ob_rd !== 5'd4) begin
      $display("FAIL auipc_const: pc=%h pce=%b imm=%h rd=%0d required 100 1 12345000 4",
               ob_pc, ob_pce, ob_imm, ob_rd);
    end else n_pass++;
  endtask

  task automatic test_random();
    sel = 1'b0;
    for (int i = 0; i < 20; i++) run_inst(rand_legal(), $urandom, 1);
  endtask

  task automatic test_back_to_back();
    sel = 1'b1;
    for (int i = 0; i < 8; i++) run_inst(rand_legal(), $urandom, 4);
    sel = 1'b0;
  endtask

  task automatic test_illegal();
    logic bad;
    sel = 1'b0;
    run_inst(32'h0000_0000, 32'h200, 1);
`ifdef ID_ILLEGAL_HALT_EN
    bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (ready_a !== 1'b0 || ex_a !== 1'b0 || wb_a !== 1'b0) bad = 1'b1;
    end
    n_total++;
    if (bad) $display("FAIL halt_hold: rdy/ex/wb became nonzero, required 0 while halted");
    else n_pass++;
`else
    run_inst(32'h002091B3, 32'h204, 1);
    run_inst(32'h0000_2013, 32'h208, 1);
    run_inst(32'h4020_F1B3, 32'h20C, 1);
    bad = 1'b0;
    run_inst(32'h002081B3, 32'h210, 1);
    n_total++;
    if (bad !== 1'b0 || ob_rd !== 5'd3) $display("FAIL after_illegal: rd=%0d required 3", ob_rd);
    else n_pass++;
`endif
  endtask

  task automatic test_async_reset();
    int n;
    sel = 1'b0;
    do_reset();
    regs[1] = 32'hDEAD_0001; regs[2] = 32'h0000_BEEF;
    n = 0;
    while (ready_a !== 1'b1 && n < 40) begin @(negedge clk); n++; end
    inst = 32'h002081B3; inst_pc = 32'h300; valid_a = 1'b1;
    @(posedge clk);
    @(negedge clk); valid_a = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_total++;
    if (ex_a !== 1'b1) $display("FAIL strobe_before_reset: ex=%b required 1", ex_a);
    else n_pass++;
    #2 rst = 1'b0;
    #1;
    n_total++;
    if ({ex_a, wb_a, ill_a, rdwe_a, pce_a, ime_a, ready_a, pc_a, r1_a, r2_a, imm_a, op_a, rd_a} !== '0) begin
      $display("FAIL async_reset: ex=%b wb=%b pc=%h r1=%h r2=%h imm=%h op=%0d rd=%0d required all zero",
               ex_a, wb_a, pc_a, r1_a, r2_a, imm_a, op_a, rd_a);
    end else n_pass++;
    @(negedge clk);
    rst = 1'b1;
    run_inst(32'h002081B3, 32'h304, 1);
  endtask

  initial begin
    tbl[0]  = '{32'h33, 6,  0,    0, 0};
    tbl[1]  = '{32'h33, 7,  0,    1, 0};
    tbl[2]  = '{32'h33, 4,  0,    2, 0};
    tbl[3]  = '{32'h33, 0,  0,    3, 0};
    tbl[4]  = '{32'h33, 0,  32,   4, 0};
    tbl[5]  = '{32'h13, 6,  -1,   0, 1};
    tbl[6]  = '{32'h13, 7,  -1,   1, 1};
    tbl[7]  = '{32'h13, 4,  -1,   2, 1};
    tbl[8]  = '{32'h13, 0,  -1,   3, 1};
    tbl[9]  = '{32'h37, -1, -1,   3, 2};
    tbl[10] = '{32'h17, -1, -1,   3, 3};
    for (int i = 0; i < 32; i++) regs[i] = $urandom;
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_illegal();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
`default_nettype wire
